// File: rtl/robot_leg_drive_sequencer.sv
// Drive sequencer for a two-motor leg platform: ramps one shared speed toward the commanded
// target, brakes and inserts a dead-time before any reversal, and stops on watchdog expiry.
module robot_leg_drive_sequencer #(
    parameter int unsigned RAMP_TICK   = 100000,
    parameter int unsigned DEADTIME    = 50000,
    parameter int unsigned WDT_TIMEOUT = 50000000,
    parameter int unsigned MAX_SPEED   = 100
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_dir,
    input  logic [7:0] cmd_speed,
    output logic [7:0] out_left_speed,
    output logic [7:0] out_right_speed,
    output logic [3:0] out_direction,
    output logic       busy,
    output logic       wdt_stop
);

    localparam int unsigned PreW  = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
    localparam int unsigned DeadW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int unsigned WdtW  = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;

    localparam logic [PreW-1:0]  PreLast  = PreW'(RAMP_TICK - 1);
    localparam logic [DeadW-1:0] DeadLast = DeadW'(DEADTIME - 1);
    localparam logic [WdtW-1:0]  WdtLast  = WdtW'(WDT_TIMEOUT - 1);
    localparam logic [7:0]       SpeedCap = (MAX_SPEED > 255) ? 8'd255 : 8'(MAX_SPEED);

    localparam logic [2:0] DirStop  = 3'd0;
    localparam logic [2:0] DirFwd   = 3'd1;
    localparam logic [2:0] DirBwd   = 3'd2;
    localparam logic [2:0] DirLeft  = 3'd3;
    localparam logic [2:0] DirRight = 3'd4;

    typedef enum logic [1:0] {StIdle, StRun, StBrake, StDead} state_e;

    state_e           state_q, state_d;
    logic [PreW-1:0]  presc_q, presc_d;
    logic [WdtW-1:0]  wdt_q, wdt_d;
    logic             wdt_stop_q, wdt_stop_d;
    logic [2:0]       pend_dir_q, pend_dir_n;
    logic [7:0]       pend_speed_q, pend_speed_n;
    logic [2:0]       active_q, active_d;
    logic [7:0]       target_q, target_d, target_n;
    logic [7:0]       cur_q, cur_d;
    logic [DeadW-1:0] dead_q, dead_d;
    logic [3:0]       dir_q, dir_d;
    logic             busy_q, busy_d;

    logic       tick;
    logic       expire;
    logic       eff_valid;
    logic [2:0] eff_dir;
    logic [7:0] eff_speed;
    logic       dir_change;
    logic       dead_done;
    logic [7:0] run_step;
    logic [7:0] brake_step;

    function automatic logic [3:0] dir_code(input logic [2:0] d);
        logic [3:0] code;
        case (d)
            DirFwd:   code = 4'b1010;
            DirBwd:   code = 4'b0101;
            DirLeft:  code = 4'b1001;
            DirRight: code = 4'b0110;
            default:  code = 4'b0000;
        endcase
        return code;
    endfunction

    // Command path: a real command always beats the watchdog; expiry injects a single stop.
    always_comb begin
        expire    = !cmd_valid && (wdt_q == WdtLast) && !wdt_stop_q;
        eff_valid = cmd_valid || expire;
        eff_dir   = DirStop;
        eff_speed = 8'd0;
        if (cmd_valid && (cmd_dir >= DirFwd) && (cmd_dir <= DirRight)) begin
            eff_dir   = cmd_dir;
            eff_speed = (cmd_speed > SpeedCap) ? SpeedCap : cmd_speed;
        end
        pend_dir_n   = eff_valid ? eff_dir : pend_dir_q;
        pend_speed_n = eff_valid ? eff_speed : pend_speed_q;

        if (cmd_valid) begin
            wdt_d = '0;
        end else if (wdt_q == WdtLast) begin
            wdt_d = wdt_q;
        end else begin
            wdt_d = wdt_q + WdtW'(1);
        end

        if (cmd_valid) begin
            wdt_stop_d = 1'b0;
        end else if (expire) begin
            wdt_stop_d = 1'b1;
        end else begin
            wdt_stop_d = wdt_stop_q;
        end
    end

    always_comb begin
        tick    = (presc_q == PreLast);
        presc_d = tick ? '0 : presc_q + PreW'(1);

        target_n = target_q;
        if (eff_valid) begin
            if (eff_dir == DirStop) begin
                target_n = 8'd0;
            end else if (eff_dir == active_q) begin
                target_n = eff_speed;
            end
        end
        dir_change = eff_valid && (eff_dir != DirStop) && (eff_dir != active_q);

        run_step = cur_q;
        if (tick) begin
            if (cur_q < target_n) begin
                run_step = cur_q + 8'd1;
            end else if (cur_q > target_n) begin
                run_step = cur_q - 8'd1;
            end
        end
        brake_step = (tick && (cur_q != 8'd0)) ? cur_q - 8'd1 : cur_q;
        dead_done  = (dead_q == DeadLast);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pend_dir_n != DirStop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (dir_change) begin
                    state_d = (cur_q == 8'd0) ? StDead : StBrake;
                end else if ((pend_dir_n == DirStop) && (run_step == 8'd0)) begin
                    state_d = StIdle;
                end
            end
            StBrake: begin
                if (brake_step == 8'd0) begin
                    state_d = StDead;
                end
            end
            StDead: begin
                if (dead_done) begin
                    state_d = (pend_dir_n != DirStop) ? StRun : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so every registered output moves on the
    // same edge as the state transition that causes it.
    always_comb begin
        cur_d    = cur_q;
        target_d = target_q;
        active_d = active_q;
        dead_d   = dead_q;
        dir_d    = 4'b0000;
        busy_d   = (state_d == StBrake) || (state_d == StDead);
        unique case (state_d)
            StRun: begin
                if (state_q == StRun) begin
                    cur_d    = run_step;
                    target_d = target_n;
                    dir_d    = dir_code(active_q);
                end else begin
                    active_d = pend_dir_n;
                    target_d = pend_speed_n;
                    cur_d    = 8'd0;
                    dir_d    = dir_code(pend_dir_n);
                end
            end
            StBrake: begin
                cur_d = brake_step;
                dir_d = dir_code(active_q);
            end
            StDead: begin
                cur_d  = 8'd0;
                dead_d = (state_q == StDead) ? dead_q + DeadW'(1) : '0;
            end
            default: begin
                cur_d    = 8'd0;
                target_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_q      <= '0;
            wdt_q        <= '0;
            wdt_stop_q   <= 1'b0;
            pend_dir_q   <= DirStop;
            pend_speed_q <= 8'd0;
            active_q     <= DirStop;
            target_q     <= 8'd0;
            cur_q        <= 8'd0;
            dead_q       <= '0;
            dir_q        <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            wdt_q        <= wdt_d;
            wdt_stop_q   <= wdt_stop_d;
            pend_dir_q   <= pend_dir_n;
            pend_speed_q <= pend_speed_n;
            active_q     <= active_d;
            target_q     <= target_d;
            cur_q        <= cur_d;
            dead_q       <= dead_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
        end
    end

    assign out_left_speed  = cur_q;
    assign out_right_speed = cur_q;
    assign out_direction   = dir_q;
    assign busy            = busy_q;
    assign wdt_stop        = wdt_stop_q;

endmodule
